spi_master_arb_ctrl: RTL and testbench

- Master-side SPI transaction controller that shares one SPI link to the on-chip SPI slave between two requesters (port 0 and port 1).
- Arbitrates between the requesters round-robin and frames each accepted 10-bit command word on SS_n/MOSI.
- For read-data commands, captures the 8-bit slave reply from MISO.
- Returns completion status and read data to the requester that owns the transaction.

---
 rtl/spi_master_arb_ctrl_if.sv | 23 ++
 rtl/spi_master_arb_ctrl.sv | 205 ++++++++++++++++++++
 tb/tb_spi_master_arb_ctrl.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/spi_master_arb_ctrl_if.sv
// Requester-side bus of the shared SPI master: two command ports in, completion status out.
interface spi_master_arb_ctrl_if #(
    parameter int unsigned ADDR_SIZE = 8
);
    logic [1:0]           req;
    logic [ADDR_SIZE+1:0] word0;
    logic [ADDR_SIZE+1:0] word1;
    logic [1:0]           ack;
    logic                 done;
    logic                 done_id;
    logic [ADDR_SIZE-1:0] rdata;
    logic                 rdata_valid;
    logic                 busy;

    modport master (
        output req, word0, word1,
        input  ack, done, done_id, rdata, rdata_valid, busy
    );
    modport slave (
        input  req, word0, word1,
        output ack, done, done_id, rdata, rdata_valid, busy
    );
endinterface

// File: rtl/spi_master_arb_ctrl.sv
// Round-robin SPI master shared by two requesters: frames 10-bit command words on SS_n/MOSI
// and captures the slave's reply byte from MISO for read-data commands.
module spi_master_arb_ctrl #(
    parameter int unsigned ADDR_SIZE = 8,
    parameter int unsigned RD_LAT    = 1,
    parameter int unsigned GAP       = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    spi_master_arb_ctrl_if.slave bus_if,
    output logic                 SS_n,
    output logic                 MOSI,
    input  logic                 MISO
);
    localparam int unsigned WW         = ADDR_SIZE + 2;
    localparam int unsigned CNT_MAX0   = (WW > GAP) ? WW : GAP;
    localparam int unsigned CNT_MAX    = (CNT_MAX0 > RD_LAT) ? CNT_MAX0 : RD_LAT;
    localparam int unsigned CNT_W      = $clog2(CNT_MAX + 1);
    localparam int unsigned SHIFT_LAST = WW - 1;
    localparam int unsigned WAIT_LAST  = (RD_LAT > 0) ? RD_LAT - 1 : 0;
    localparam int unsigned RECV_LAST  = ADDR_SIZE - 1;
    localparam int unsigned GAP_LAST   = (GAP > 0) ? GAP - 1 : 0;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_CMD   = 3'd1;
    localparam logic [2:0] ST_SHIFT = 3'd2;
    localparam logic [2:0] ST_WAIT  = 3'd3;
    localparam logic [2:0] ST_RECV  = 3'd4;
    localparam logic [2:0] ST_GAP   = 3'd5;

    logic [2:0]           state_q,       state_d;
    logic [CNT_W-1:0]     cnt_q,         cnt_d;
    logic [WW-1:0]        shreg_q,       shreg_d;
    logic [ADDR_SIZE-1:0] rx_q,          rx_d;
    logic                 rd_q,          rd_d;
    logic                 owner_q,       owner_d;
    logic                 rr_last_q,     rr_last_d;
    logic [1:0]           ack_q,         ack_d;
    logic                 done_q,        done_d;
    logic                 done_id_q,     done_id_d;
    logic [ADDR_SIZE-1:0] rdata_q,       rdata_d;
    logic                 rdata_valid_q, rdata_valid_d;
    logic                 busy_q,        busy_d;
    logic                 ss_n_q,        ss_n_d;
    logic                 mosi_q,        mosi_d;

    logic                 grant0_c;
    logic                 grant1_c;
    logic [WW-1:0]        sel_word_c;

    // On contention the port that did not win last time gets the link.
    assign grant0_c   = bus_if.req[0] & (~bus_if.req[1] | rr_last_q);
    assign grant1_c   = bus_if.req[1] & (~bus_if.req[0] | ~rr_last_q);
    assign sel_word_c = grant1_c ? bus_if.word1 : bus_if.word0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            shreg_q       <= '0;
            rx_q          <= '0;
            rd_q          <= 1'b0;
            owner_q       <= 1'b0;
            rr_last_q     <= 1'b1;
            ack_q         <= 2'b00;
            done_q        <= 1'b0;
            done_id_q     <= 1'b0;
            rdata_q       <= '0;
            rdata_valid_q <= 1'b0;
            busy_q        <= 1'b0;
            ss_n_q        <= 1'b1;
            mosi_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            shreg_q       <= shreg_d;
            rx_q          <= rx_d;
            rd_q          <= rd_d;
            owner_q       <= owner_d;
            rr_last_q     <= rr_last_d;
            ack_q         <= ack_d;
            done_q        <= done_d;
            done_id_q     <= done_id_d;
            rdata_q       <= rdata_d;
            rdata_valid_q <= rdata_valid_d;
            busy_q        <= busy_d;
            ss_n_q        <= ss_n_d;
            mosi_q        <= mosi_d;
        end
    end

    // Output registers are loaded with the values of the state being entered,
    // so SS_n/MOSI line up with the state cycle that owns them.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        shreg_d       = shreg_q;
        rx_d          = rx_q;
        rd_d          = rd_q;
        owner_d       = owner_q;
        rr_last_d     = rr_last_q;
        ack_d         = 2'b00;
        done_d        = 1'b0;
        done_id_d     = done_id_q;
        rdata_d       = rdata_q;
        rdata_valid_d = 1'b0;
        busy_d        = busy_q;
        ss_n_d        = ss_n_q;
        mosi_d        = mosi_q;

        case (state_q)
            ST_IDLE: begin
                ss_n_d = 1'b1;
                mosi_d = 1'b0;
                if (grant0_c || grant1_c) begin
                    ack_d     = {grant1_c, grant0_c};
                    shreg_d   = sel_word_c;
                    rd_d      = (sel_word_c[WW-1 -: 2] == 2'b11);
                    owner_d   = grant1_c;
                    rr_last_d = grant1_c;
                    busy_d    = 1'b1;
                    ss_n_d    = 1'b0;
                    mosi_d    = sel_word_c[WW-1];
                    state_d   = ST_CMD;
                end
            end
            ST_CMD: begin
                // The command-check bit is repeated as the first word bit.
                mosi_d  = shreg_q[WW-1];
                cnt_d   = '0;
                state_d = ST_SHIFT;
            end
            ST_SHIFT: begin
                if (cnt_q == CNT_W'(SHIFT_LAST)) begin
                    cnt_d  = '0;
                    mosi_d = 1'b0;
                    if (rd_q) begin
                        state_d = (RD_LAT == 0) ? ST_RECV : ST_WAIT;
                    end else begin
                        state_d   = ST_GAP;
                        ss_n_d    = 1'b1;
                        done_d    = 1'b1;
                        done_id_d = owner_q;
                    end
                end else begin
                    cnt_d   = cnt_q + CNT_W'(1);
                    mosi_d  = shreg_q[WW-2];
                    shreg_d = {shreg_q[WW-2:0], 1'b0};
                end
            end
            ST_WAIT: begin
                mosi_d = 1'b0;
                if (cnt_q == CNT_W'(WAIT_LAST)) begin
                    cnt_d   = '0;
                    state_d = ST_RECV;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_RECV: begin
                mosi_d = 1'b0;
                rx_d   = ADDR_SIZE'({rx_q, MISO});
                if (cnt_q == CNT_W'(RECV_LAST)) begin
                    cnt_d         = '0;
                    state_d       = ST_GAP;
                    ss_n_d        = 1'b1;
                    done_d        = 1'b1;
                    done_id_d     = owner_q;
                    rdata_d       = ADDR_SIZE'({rx_q, MISO});
                    rdata_valid_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_GAP: begin
                ss_n_d = 1'b1;
                mosi_d = 1'b0;
                if (cnt_q == CNT_W'(GAP_LAST)) begin
                    cnt_d   = '0;
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
                ss_n_d  = 1'b1;
                mosi_d  = 1'b0;
                busy_d  = 1'b0;
            end
        endcase
    end

    assign bus_if.ack         = ack_q;
    assign bus_if.done        = done_q;
    assign bus_if.done_id     = done_id_q;
    assign bus_if.rdata       = rdata_q;
    assign bus_if.rdata_valid = rdata_valid_q;
    assign bus_if.busy        = busy_q;
    assign SS_n               = ss_n_q;
    assign MOSI               = mosi_q;

endmodule

// File: tb/tb_spi_master_arb_ctrl.sv
// Directed bench for spi_master_arb_ctrl: table of single frames plus hand-written
// contention, dropped-request and mid-frame reset sequences.
module tb_spi_master_arb_ctrl;
    localparam int unsigned ADDR_SIZE = 8;
    localparam int unsigned RD_LAT    = 1;
    localparam int unsigned GAP       = 2;
    localparam int unsigned WW        = ADDR_SIZE + 2;

    typedef struct {
        logic [1:0]           req;
        logic [WW-1:0]        w0;
        logic [WW-1:0]        w1;
        logic [ADDR_SIZE-1:0] miso_byte;
        int                   exp_port;
        logic [ADDR_SIZE-1:0] exp_rdata;
        logic                 exp_valid;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    logic SS_n;
    logic MOSI;
    logic MISO;

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    int ack_cnt = 0;
    int done_cnt = 0;
    int last_done_cyc = 0;

    spi_master_arb_ctrl_if #(.ADDR_SIZE(ADDR_SIZE)) bus_if ();

    spi_master_arb_ctrl #(
        .ADDR_SIZE(ADDR_SIZE),
        .RD_LAT   (RD_LAT),
        .GAP      (GAP)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .bus_if(bus_if),
        .SS_n  (SS_n),
        .MOSI  (MOSI),
        .MISO  (MISO)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (bus_if.ack != 2'b00) ack_cnt <= ack_cnt + 1;
        if (bus_if.done) done_cnt <= done_cnt + 1;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic timeout_fail(input string name);
        n_vec++;
        n_err++;
        $display("FAIL %s: no response within cycle budget", name);
    endtask

    // Issue one request and follow its frame through to the end of GAP.
    task automatic run_frame(input vec_t v, input bit chk_gap, input int pulse_at);
        logic [WW:0]   mosi_bits;
        logic [WW:0]   exp_bits;
        logic [WW-1:0] w;
        bit            rd;
        bit            got;
        int            exp_lat;
        int            ss_low;
        int            done_c;
        int            c;

        w       = (v.exp_port == 1) ? v.w1 : v.w0;
        rd      = (w[WW-1 -: 2] == 2'b11);
        exp_lat = rd ? int'(1 + WW + RD_LAT + ADDR_SIZE) : int'(1 + WW);

        bus_if.req   = v.req;
        bus_if.word0 = v.w0;
        bus_if.word1 = v.w1;
        got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(posedge clk);
            #1;
            if (bus_if.ack != 2'b00) got = 1'b1;
        end
        if (!got) begin
            timeout_fail("ack_wait");
            bus_if.req = 2'b00;
            return;
        end
        check("ack", 32'(bus_if.ack), (v.exp_port == 1) ? 32'd2 : 32'd1);
        if (chk_gap) check("ss_high_gap", 32'(cyc - last_done_cyc), 32'(GAP + 1));

        // Requester drops its request and scribbles on its word once accepted.
        bus_if.req[v.exp_port] = 1'b0;
        if (v.exp_port == 1) bus_if.word1 = ~v.w1;
        else                 bus_if.word0 = ~v.w0;

        mosi_bits = '0;
        ss_low    = 0;
        done_c    = -1;
        for (c = 0; c < 60; c++) begin
            if (c > 0) begin
                @(posedge clk);
                #1;
            end
            if (pulse_at != 0 && c == pulse_at)          bus_if.req[0] = 1'b1;
            else if (pulse_at != 0 && c == pulse_at + 1) bus_if.req[0] = 1'b0;
            if (rd && c >= int'(1 + WW + RD_LAT) && c < exp_lat) MISO = v.miso_byte[exp_lat - 1 - c];
            else                                                  MISO = 1'b0;
            if (bus_if.done) begin
                done_c = c;
                break;
            end
            if (SS_n == 1'b0) begin
                ss_low++;
                if (ss_low <= int'(WW + 1)) mosi_bits = {mosi_bits[WW-1:0], MOSI};
            end
        end
        MISO = 1'b0;
        if (done_c < 0) begin
            timeout_fail("done_wait");
            bus_if.req = 2'b00;
            return;
        end
        exp_bits = {w[WW-1], w};
        check("latency",       32'(done_c),             32'(exp_lat));
        check("ss_low_cycles", 32'(ss_low),             32'(exp_lat));
        check("mosi_bits",     32'(mosi_bits),          32'(exp_bits));
        check("done_id",       32'(bus_if.done_id),     32'(v.exp_port));
        check("rdata",         32'(bus_if.rdata),       32'(v.exp_rdata));
        check("rdata_valid",   32'(bus_if.rdata_valid), 32'(v.exp_valid));
        check("ss_n_at_done",  32'(SS_n),               32'd1);
        check("busy_at_done",  32'(bus_if.busy),        32'd1);
        last_done_cyc = cyc;
        repeat (GAP) begin
            @(posedge clk);
            #1;
        end
        check("busy_after_gap", 32'(bus_if.busy), 32'd0);
    endtask

    vec_t tbl [5];
    vec_t cv0, cv1, pv;
    int   a_before;
    int   d_before;
    bit   got;

    initial begin
        tbl[0] = '{2'b01, 10'b00_1010_0101, 10'b0,             8'h00, 0, 8'h00, 1'b0};
        tbl[1] = '{2'b10, 10'b0,            10'b11_0000_0000, 8'hB3, 1, 8'hB3, 1'b1};
        tbl[2] = '{2'b01, 10'b01_0011_1100, 10'b0,             8'h00, 0, 8'hB3, 1'b0};
        tbl[3] = '{2'b10, 10'b0,            10'b10_1111_0000, 8'hFF, 1, 8'hB3, 1'b0};
        tbl[4] = '{2'b01, 10'b11_0101_0101, 10'b0,             8'h5C, 0, 8'h5C, 1'b1};

        rst          = 1'b1;
        MISO         = 1'b0;
        bus_if.req   = 2'b00;
        bus_if.word0 = '0;
        bus_if.word1 = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_ss_n",        32'(SS_n),               32'd1);
        check("rst_mosi",        32'(MOSI),               32'd0);
        check("rst_ack",         32'(bus_if.ack),         32'd0);
        check("rst_done",        32'(bus_if.done),        32'd0);
        check("rst_done_id",     32'(bus_if.done_id),     32'd0);
        check("rst_rdata",       32'(bus_if.rdata),       32'd0);
        check("rst_rdata_valid", 32'(bus_if.rdata_valid), 32'd0);
        check("rst_busy",        32'(bus_if.busy),        32'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 5; i++) run_frame(tbl[i], 1'b0, 0);

        // Short req0 pulse while busy must be forgotten.
        pv = '{2'b10, 10'b0, 10'b00_0111_1000, 8'h00, 1, 8'h5C, 1'b0};
        a_before = ack_cnt;
        run_frame(pv, 1'b0, 5);
        repeat (10) @(posedge clk);
        #1;
        check("pulse_dropped_acks", 32'(ack_cnt - a_before), 32'd1);
        check("pulse_dropped_ss_n", 32'(SS_n),               32'd1);

        // Reset in the middle of SHIFT abandons the frame.
        bus_if.req   = 2'b01;
        bus_if.word0 = 10'b10_0110_1001;
        got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(posedge clk);
            #1;
            if (bus_if.ack != 2'b00) got = 1'b1;
        end
        if (!got) timeout_fail("rst_ack_wait");
        bus_if.req = 2'b00;
        repeat (5) @(posedge clk);
        #1;
        check("pre_rst_ss_n", 32'(SS_n), 32'd0);
        d_before = done_cnt;
        rst = 1'b1;
        #1;
        check("midrst_ss_n", 32'(SS_n),        32'd1);
        check("midrst_busy", 32'(bus_if.busy), 32'd0);
        check("midrst_mosi", 32'(MOSI),        32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        check("midrst_no_done", 32'(done_cnt - d_before), 32'd0);
        check("midrst_idle_ss", 32'(SS_n),                32'd1);

        // Both ports held: grants alternate starting with port 0.
        cv0 = '{2'b11, 10'b01_1100_0011, 10'b00_0000_1111, 8'h00, 0, 8'h00, 1'b0};
        cv1 = '{2'b11, 10'b01_1100_0011, 10'b00_0000_1111, 8'h00, 1, 8'h00, 1'b0};
        run_frame(cv0, 1'b0, 0);
        run_frame(cv1, 1'b1, 0);
        run_frame(cv0, 1'b1, 0);
        bus_if.req = 2'b00;
        repeat (40) @(posedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
